// File: rtl/minterm_pkg.sv
// rtl/minterm_pkg.sv - shared FSM state type and limits for the minterm sweeper
package minterm_pkg;

    localparam int MAX_N = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/minterm_counter.sv
// rtl/minterm_counter.sv - minterm index counter with clear, enable and terminal flag
module minterm_counter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [N-1:0] idx,
    output logic         last
);

    logic [N-1:0] idx_q;
    logic [N-1:0] idx_d;

    always_comb begin
        idx_d = idx_q;
        if (clr) begin
            idx_d = '0;
        end else if (en) begin
            idx_d = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign idx  = idx_q;
    // W-1 is all ones because W is a power of two
    assign last = &idx_q;

endmodule

// File: rtl/minterm_sweeper.sv
// rtl/minterm_sweeper.sv - streams every minterm of a loaded truth table and classifies the function
module minterm_sweeper
    import minterm_pkg::*;
#(
    parameter int N = 3,
    localparam int W = 2 ** N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] tt_in,
    input  logic         start,
    input  logic         out_ready,
    output logic         busy,
    output logic         out_valid,
    output logic [N-1:0] out_idx,
    output logic         out_s,
    output logic         done,
    output logic [N:0]   ones_count,
    output logic         result_valid,
    output logic         tautology,
    output logic         contradiction
);

    localparam logic [N:0] FULL_COUNT = {1'b1, {N{1'b0}}};

    state_e       state_q;
    state_e       state_d;
    logic [W-1:0] tt_q;
    logic [W-1:0] tt_d;
    logic [N:0]   ones_count_q;
    logic [N:0]   ones_count_d;
    logic         result_valid_q;
    logic         result_valid_d;

    logic         cnt_clr;
    logic         cnt_en;
    logic [N-1:0] idx;
    logic         idx_last;
    logic         in_sweep;
    logic         xfer;

    minterm_counter #(.N(N)) u_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .idx   (idx),
        .last  (idx_last)
    );

    assign in_sweep = (state_q == ST_SWEEP);
    assign xfer     = in_sweep && out_ready;

    always_comb begin
        state_d        = state_q;
        tt_d           = tt_q;
        ones_count_d   = ones_count_q;
        result_valid_d = result_valid_q;
        cnt_clr        = 1'b0;
        cnt_en         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // a same-cycle load lands in tt_q before the first beat is presented
                if (load) begin
                    tt_d = tt_in;
                end
                if (start) begin
                    state_d        = ST_SWEEP;
                    ones_count_d   = '0;
                    result_valid_d = 1'b0;
                    cnt_clr        = 1'b1;
                end
            end
            ST_SWEEP: begin
                if (xfer) begin
                    ones_count_d = ones_count_q + {{N{1'b0}}, tt_q[idx]};
                    if (idx_last) begin
                        state_d        = ST_DONE;
                        result_valid_d = 1'b1;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            tt_q           <= '0;
            ones_count_q   <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            tt_q           <= tt_d;
            ones_count_q   <= ones_count_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign busy          = in_sweep;
    assign out_valid     = in_sweep;
    assign out_idx       = in_sweep ? idx : '0;
    assign out_s         = in_sweep && tt_q[idx];
    assign done          = (state_q == ST_DONE);
    assign ones_count    = ones_count_q;
    assign result_valid  = result_valid_q;
    assign tautology     = result_valid_q && (ones_count_q == FULL_COUNT);
    assign contradiction = result_valid_q && (ones_count_q == '0);

endmodule

// File: tb/tb_minterm_sweeper.sv
// tb/tb_minterm_sweeper.sv - randomized self-checking bench for minterm_sweeper with a truth-table reference model
module tb_minterm_sweeper;

    localparam int N = 3;
    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         load;
    logic [W-1:0] tt_in;
    logic         start;
    logic         out_ready;
    logic         busy;
    logic         out_valid;
    logic [N-1:0] out_idx;
    logic         out_s;
    logic         done;
    logic [N:0]   ones_count;
    logic         result_valid;
    logic         tautology;
    logic         contradiction;

    int checks   = 0;
    int failures = 0;

    minterm_sweeper #(.N(N)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .load          (load),
        .tt_in         (tt_in),
        .start         (start),
        .out_ready     (out_ready),
        .busy          (busy),
        .out_valid     (out_valid),
        .out_idx       (out_idx),
        .out_s         (out_s),
        .done          (done),
        .ones_count    (ones_count),
        .result_valid  (result_valid),
        .tautology     (tautology),
        .contradiction (contradiction)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_valid"}, out_valid, 0);
        check_eq({tag, "_idx"}, out_idx, 0);
        check_eq({tag, "_s"}, out_s, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_cnt"}, ones_count, 0);
        check_eq({tag, "_rv"}, result_valid, 0);
        check_eq({tag, "_taut"}, tautology, 0);
        check_eq({tag, "_contr"}, contradiction, 0);
    endtask

    // mode 0: ready always high, 1: random ready, 2: three-cycle stall at idx 2
    task automatic run_sweep(input logic [W-1:0] tt, input int mode, input bit inject, input int abort_at);
        int   e_idx = 0;
        int   e_cnt = 0;
        int   cyc   = 0;
        int   stall = 0;
        int   ones  = $countones(tt);
        logic rdy;
        tt_in = tt;
        load  = 1'b1;
        start = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        start = 1'b0;
        tt_in = ~tt;
        cyc   = 1;
        while (e_idx < W && cyc < 200) begin
            check_eq("sw_busy", busy, 1);
            check_eq("sw_valid", out_valid, 1);
            check_eq("sw_idx", out_idx, e_idx);
            check_eq("sw_s", out_s, tt[e_idx]);
            check_eq("sw_cnt", ones_count, e_cnt);
            check_eq("sw_done", done, 0);
            check_eq("sw_rv", result_valid, 0);
            if (e_idx == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_all_zero("abort");
                @(negedge clk);
                rst_n = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    check_eq("post_abort_busy", busy, 0);
                    check_eq("post_abort_done", done, 0);
                    check_eq("post_abort_valid", out_valid, 0);
                end
                return;
            end
            case (mode)
                1:       rdy = ($urandom_range(0, 3) != 0);
                2:       begin
                    rdy = !(e_idx == 2 && stall < 3);
                    if (!rdy) stall++;
                end
                default: rdy = 1'b1;
            endcase
            out_ready = rdy;
            if (inject && e_idx == 3) begin
                load  = 1'b1;
                start = 1'b1;
                tt_in = '0;
            end else begin
                load  = 1'b0;
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
            if (rdy) begin
                e_cnt += int'(tt[e_idx]);
                e_idx++;
            end
        end
        load  = 1'b0;
        start = 1'b0;
        check_eq("sweep_bound", e_idx, W);
        check_eq("dn_done", done, 1);
        check_eq("dn_busy", busy, 0);
        check_eq("dn_valid", out_valid, 0);
        check_eq("dn_idx", out_idx, 0);
        check_eq("dn_s", out_s, 0);
        check_eq("dn_rv", result_valid, 1);
        check_eq("dn_cnt", ones_count, ones);
        check_eq("dn_taut", tautology, ones == W);
        check_eq("dn_contr", contradiction, ones == 0);
        if (mode == 0) check_eq("latency", cyc, W + 1);
        if (mode == 2) check_eq("stalls", stall, 3);
        // load without start in IDLE must not disturb the held result
        tt_in = 8'h5A;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        check_eq("idle_done", done, 0);
        check_eq("idle_busy", busy, 0);
        @(negedge clk);
        check_eq("hold_busy", busy, 0);
        check_eq("hold_rv", result_valid, 1);
        check_eq("hold_cnt", ones_count, ones);
        check_eq("hold_taut", tautology, ones == W);
    endtask

    initial begin
        logic [W-1:0] r;
        rst_n     = 1'b0;
        load      = 1'b0;
        start     = 1'b0;
        tt_in     = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        run_sweep(8'hFF, 0, 1'b0, -1);
        run_sweep(8'h00, 0, 1'b0, -1);
        run_sweep(8'h96, 0, 1'b0, -1);
        run_sweep(8'h96, 2, 1'b0, -1);
        run_sweep(8'hFF, 0, 1'b1, -1);
        r = 8'($urandom);
        run_sweep(r, 1, 1'b0, 5);
        run_sweep(8'h96, 0, 1'b0, -1);
        for (int i = 0; i < 6; i++) begin
            r = 8'($urandom);
            run_sweep(r, 1, 1'b0, -1);
        end
        for (int i = 0; i < 3; i++) begin
            r = 8'($urandom);
            run_sweep(r, 1, 1'b1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/minterm_sweeper.md
MINTERM_SWEEPER -- requirements
Module: minterm_sweeper

Interface
REQ-001 SHALL have parameter N, default 3, number of function inputs; legal range 1..6.
REQ-002 SHALL have derived local constant W = 2**N, truth-table size in minterms.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port load  input  1  capture tt_in into the truth-table register.
REQ-006 SHALL have port tt_in  input  W  truth table; bit k = function value for input combination k (MSB of k = first input).
REQ-007 SHALL have port start  input  1  begin a sweep of all W combinations.
REQ-008 SHALL have port out_ready  input  1  consumer accepts the current out_* beat.
REQ-009 SHALL have port busy  output  1  high in SWEEP.
REQ-010 SHALL have port out_valid  output  1  out_idx/out_s hold a valid beat.
REQ-011 SHALL have port out_idx  output  N  current input combination.
REQ-012 SHALL have port out_s  output  1  function value tt[out_idx].
REQ-013 SHALL have port done  output  1  one-cycle pulse when the sweep completes.
REQ-014 SHALL have port ones_count  output  N+1  number of accepted beats with out_s=1.
REQ-015 SHALL have port result_valid  output  1  ones_count/tautology/contradiction are final.
REQ-016 SHALL have port tautology  output  1  result_valid and ones_count==W.
REQ-017 SHALL have port contradiction  output  1  result_valid and ones_count==0.

Function
REQ-018 SHALL implement FSM states IDLE, SWEEP, DONE.
REQ-019 In IDLE: load=1 writes tt_in to the table; start=1 clears idx, ones_count and result_valid, then enters SWEEP.
REQ-020 load and start in the same IDLE cycle SHALL load the table and start; the sweep uses the newly loaded table.
REQ-021 load or start in SWEEP or DONE SHALL be ignored.
REQ-022 In SWEEP: out_valid=1, out_idx=idx, out_s=tt[idx], combinationally from registered idx.
REQ-023 A beat SHALL transfer only on out_valid&&out_ready; on transfer ones_count += out_s.
REQ-024 On transfer with idx<W-1, idx SHALL increment; with idx==W-1, FSM SHALL go to DONE.
REQ-025 With out_ready=0, idx, out_idx, out_s and ones_count SHALL hold stable.
REQ-026 In DONE, done=1 and result_valid SHALL be set; the FSM returns to IDLE next cycle; done lasts exactly one cycle.
REQ-027 ones_count and result_valid SHALL hold in IDLE until the next accepted start.
REQ-028 Sweep latency SHALL be W transferred beats plus 1 DONE cycle; with out_ready tied high, start to done is W+1 cycles.
REQ-029 ones_count SHALL be N+1 bits wide and must not overflow at W.
REQ-030 Outside SWEEP, out_valid=0; out_idx and out_s SHALL be 0.

Reset
REQ-031 rst_n low SHALL asynchronously force IDLE; table=0, idx=0, ones_count=0; busy, out_valid, done, result_valid, tautology and contradiction=0.
REQ-032 Reset mid-sweep SHALL abort with no done pulse; after release the block idles until start.

Structure
REQ-033 The FSM state enum and a MAX_N=6 constant SHALL live in shared package minterm_pkg.
REQ-034 The idx counter with enable and terminal flag SHALL be sub-module minterm_counter (parameter N).
REQ-035 Truth-table register, mux and FSM SHALL reside in minterm_sweeper.

Verification
REQ-036 N=3, load tt=8'hFF, start, out_ready=1 -> out_s=1 on idx 0..7, ones_count=8, tautology=1, done at cycle 9.
REQ-037 N=3, tt=8'h00 -> eight out_s=0 beats, ones_count=0, contradiction=1, tautology=0.
REQ-038 N=3, tt=8'h96 -> out_s sequence 0,1,1,0,1,0,0,1 for idx 0..7, ones_count=4, neither flag set.
REQ-039 out_ready low for 3 cycles at idx=2 -> out_idx=2, out_s stable, no count change; sweep resumes at idx 3; total 8 beats.
REQ-040 load tt=8'h00 asserted during SWEEP of 8'hFF -> ignored, result tautology=1; start during SWEEP -> no restart.
REQ-041 rst_n low at idx=5 -> all outputs 0 immediately, no done; a new start after load 8'h96 -> ones_count=4.
